// File: rtl/rps_match_controller.sv
// Rock-paper-scissors match controller: collects one move per player, presents the
// pair to the combinational judge, scores the verdict and declares the match winner.
module rps_match_controller #(
    parameter  int WIN_TARGET = 3,
    parameter  int MAX_ROUNDS = 15,
    localparam int SCORE_W    = $clog2(WIN_TARGET + 1),
    localparam int ROUND_W    = $clog2(MAX_ROUNDS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               move_a_valid,
    input  logic [2:0]         move_a,
    output logic               move_a_ready,
    input  logic               move_b_valid,
    input  logic [2:0]         move_b,
    output logic               move_b_ready,
    output logic [2:0]         judge_a,
    output logic [2:0]         judge_b,
    input  logic               judge_valid,
    input  logic               judge_tie,
    input  logic               judge_win_a,
    input  logic               judge_win_b,
    output logic               busy,
    output logic               round_done,
    output logic [1:0]         round_result,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic [ROUND_W-1:0] round_cnt,
    output logic               match_done,
    output logic [1:0]         match_winner
);

    typedef enum logic [1:0] {IDLE, COLLECT, JUDGE, DONE} state_t;

    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_TARGET);
    localparam logic [ROUND_W-1:0] ROUND_MAX = ROUND_W'(MAX_ROUNDS);

    state_t             state;
    logic               got_a;
    logic               got_b;
    logic               hs_a;
    logic               hs_b;
    logic [1:0]         verdict;
    logic [SCORE_W-1:0] score_a_nxt;
    logic [SCORE_W-1:0] score_b_nxt;
    logic [ROUND_W-1:0] round_cnt_nxt;

    assign move_a_ready = (state == COLLECT) && !got_a;
    assign move_b_ready = (state == COLLECT) && !got_b;
    assign hs_a         = move_a_valid && move_a_ready;
    assign hs_b         = move_b_valid && move_b_ready;

    // Verdict decode with priority invalid > tie > A > B; a valid verdict naming no
    // outcome is scored like an invalid one.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        verdict       = 2'b00;
        score_a_nxt   = score_a;
        score_b_nxt   = score_b;
        round_cnt_nxt = round_cnt;
        if (judge_valid) begin
            if (judge_tie) begin
                verdict       = 2'b11;
                round_cnt_nxt = round_cnt + 1'b1;
            end else if (judge_win_a) begin
                verdict       = 2'b01;
                score_a_nxt   = score_a + 1'b1;
                round_cnt_nxt = round_cnt + 1'b1;
            end else if (judge_win_b) begin
                verdict       = 2'b10;
                score_b_nxt   = score_b + 1'b1;
                round_cnt_nxt = round_cnt + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            got_a        <= 1'b0;
            got_b        <= 1'b0;
            judge_a      <= 3'b000;
            judge_b      <= 3'b000;
            busy         <= 1'b0;
            round_done   <= 1'b0;
            round_result <= 2'b00;
            score_a      <= '0;
            score_b      <= '0;
            round_cnt    <= '0;
            match_done   <= 1'b0;
            match_winner <= 2'b00;
        end else begin
            round_done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        score_a      <= '0;
                        score_b      <= '0;
                        round_cnt    <= '0;
                        got_a        <= 1'b0;
                        got_b        <= 1'b0;
                        match_done   <= 1'b0;
                        match_winner <= 2'b00;
                        busy         <= 1'b1;
                        state        <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (hs_a) begin
                        judge_a <= move_a;
                        got_a   <= 1'b1;
                    end
                    if (hs_b) begin
                        judge_b <= move_b;
                        got_b   <= 1'b1;
                    end
                    if ((got_a || hs_a) && (got_b || hs_b)) begin
                        state <= JUDGE;
                    end
                end
                JUDGE: begin
                    round_done   <= 1'b1;
                    round_result <= verdict;
                    score_a      <= score_a_nxt;
                    score_b      <= score_b_nxt;
                    round_cnt    <= round_cnt_nxt;
                    got_a        <= 1'b0;
                    got_b        <= 1'b0;
                    // A win on the last allowed round beats the draw.
                    if (score_a_nxt == WIN_VAL) begin
                        match_winner <= 2'b01;
                        match_done   <= 1'b1;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end else if (score_b_nxt == WIN_VAL) begin
                        match_winner <= 2'b10;
                        match_done   <= 1'b1;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end else if (round_cnt_nxt == ROUND_MAX) begin
                        match_winner <= 2'b11;
                        match_done   <= 1'b1;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end else begin
                        state <= COLLECT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rps_match_controller.sv
// Bench for rps_match_controller: a round/score model checked every cycle against the
// DUT, with an environment judge and directed match scenarios.
module tb_rps_match_controller;

    localparam int WT = 3;
    localparam int MR = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       move_a_valid = 1'b0;
    logic       move_b_valid = 1'b0;
    logic [2:0] move_a = 3'b000;
    logic [2:0] move_b = 3'b000;
    logic       move_a_ready, move_b_ready;
    logic [2:0] judge_a, judge_b;
    logic       judge_valid, judge_tie, judge_win_a, judge_win_b;
    logic       busy, round_done, match_done;
    logic [1:0] round_result, match_winner;
    logic [1:0] score_a, score_b;
    logic [2:0] round_cnt;

    int checks = 0;
    int errors = 0;

    // Forced judge verdict {valid, tie, win_a, win_b} to exercise decode priority.
    logic       jovr = 1'b0;
    logic [3:0] jval = 4'b0000;

    always #5 clk = ~clk;

    rps_match_controller #(.WIN_TARGET(WT), .MAX_ROUNDS(MR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .move_a_valid(move_a_valid), .move_a(move_a), .move_a_ready(move_a_ready),
        .move_b_valid(move_b_valid), .move_b(move_b), .move_b_ready(move_b_ready),
        .judge_a(judge_a), .judge_b(judge_b),
        .judge_valid(judge_valid), .judge_tie(judge_tie),
        .judge_win_a(judge_win_a), .judge_win_b(judge_win_b),
        .busy(busy), .round_done(round_done), .round_result(round_result),
        .score_a(score_a), .score_b(score_b), .round_cnt(round_cnt),
        .match_done(match_done), .match_winner(match_winner)
    );

    function automatic logic beats(input logic [2:0] x, input logic [2:0] y);
        return (x == 3'b001 && y == 3'b100) || (x == 3'b010 && y == 3'b001) ||
               (x == 3'b100 && y == 3'b010);
    endfunction

    wire legal = $onehot(judge_a) && $onehot(judge_b);
    assign judge_valid = jovr ? jval[3] : legal;
    assign judge_tie   = jovr ? jval[2] : legal && (judge_a == judge_b);
    assign judge_win_a = jovr ? jval[1] : legal && beats(judge_a, judge_b);
    assign judge_win_b = jovr ? jval[0] : legal && beats(judge_b, judge_a);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: match phase flags, moves held per player, scores as integers.
    bit         m_collect = 0, m_judge = 0, m_over = 0, m_have_a = 0, m_have_b = 0, m_rdone = 0;
    logic [2:0] m_a = 3'b000, m_b = 3'b000;
    logic [1:0] m_rres = 2'b00, m_winner = 2'b00;
    int         m_sa = 0, m_sb = 0, m_rounds = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit ra, rb;
        if (!rst_n) begin
            m_collect = 0; m_judge = 0; m_over = 0; m_have_a = 0; m_have_b = 0; m_rdone = 0;
            m_a = 3'b000; m_b = 3'b000; m_rres = 2'b00; m_winner = 2'b00;
            m_sa = 0; m_sb = 0; m_rounds = 0;
        end else begin
            m_rdone = 0;
            if (m_judge) begin
                m_judge = 0; m_rdone = 1; m_have_a = 0; m_have_b = 0;
                if (!judge_valid)     m_rres = 2'b00;
                else if (judge_tie)   begin m_rres = 2'b11; m_rounds++; end
                else if (judge_win_a) begin m_rres = 2'b01; m_sa++; m_rounds++; end
                else if (judge_win_b) begin m_rres = 2'b10; m_sb++; m_rounds++; end
                else                  m_rres = 2'b00;
                if (m_sa == WT)          begin m_over = 1; m_winner = 2'b01; end
                else if (m_sb == WT)     begin m_over = 1; m_winner = 2'b10; end
                else if (m_rounds == MR) begin m_over = 1; m_winner = 2'b11; end
                else m_collect = 1;
            end else if (m_collect) begin
                ra = !m_have_a;
                rb = !m_have_b;
                if (move_a_valid && ra) begin m_a = move_a; m_have_a = 1; end
                if (move_b_valid && rb) begin m_b = move_b; m_have_b = 1; end
                if (m_have_a && m_have_b) begin m_collect = 0; m_judge = 1; end
            end else if (start) begin
                m_sa = 0; m_sb = 0; m_rounds = 0; m_have_a = 0; m_have_b = 0;
                m_over = 0; m_winner = 2'b00; m_collect = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("ready_a", move_a_ready, m_collect && !m_have_a);
        check("ready_b", move_b_ready, m_collect && !m_have_b);
        check("busy", busy, m_collect || m_judge);
        check("judge_a", judge_a, m_a);
        check("judge_b", judge_b, m_b);
        check("round_done", round_done, m_rdone);
        if (m_rdone) check("round_result", round_result, m_rres);
        check("score_a", score_a, m_sa);
        check("score_b", score_b, m_sb);
        check("round_cnt", round_cnt, m_rounds);
        check("match_done", match_done, m_over);
        check("match_winner", match_winner, m_winner);
    end

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_round;
        int n = 0;
        while (!round_done && n < 6) begin
            @(negedge clk);
            n++;
        end
        check("round_done_seen", round_done, 1);
    endtask

    task automatic play(input logic [2:0] a, input logic [2:0] b);
        bit pa = 1, pb = 1, ha, hb;
        @(negedge clk);
        move_a = a; move_b = b; move_a_valid = 1'b1; move_b_valid = 1'b1;
        for (int i = 0; i < 20 && (pa || pb); i++) begin
            ha = move_a_valid && move_a_ready;
            hb = move_b_valid && move_b_ready;
            @(negedge clk);
            if (ha) begin pa = 0; move_a_valid = 1'b0; end
            if (hb) begin pb = 0; move_b_valid = 1'b0; end
        end
        check("handshake_timeout", {pa, pb}, 0);
        move_a_valid = 1'b0; move_b_valid = 1'b0;
        wait_round();
    endtask

    task automatic play_forced(input logic [2:0] a, input logic [2:0] b, input logic [3:0] v);
        jovr = 1'b1; jval = v;
        play(a, b);
        jovr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_busy", busy, 0);
        check("reset_winner", match_winner, 0);

        // Asynchronous reset mid-COLLECT with A already captured.
        pulse_start();
        @(negedge clk); move_a = 3'b001; move_a_valid = 1'b1;
        @(negedge clk); move_a_valid = 1'b0;
        check("t1_ready_a_low", move_a_ready, 0);
        check("t1_judge_a", judge_a, 3'b001);
        #2 rst_n = 1'b0;
        #1;
        check("t1_rst_judge_a", judge_a, 0);
        check("t1_rst_ready_b", move_b_ready, 0);
        check("t1_rst_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;

        // Three straight A wins.
        pulse_start();
        repeat (3) begin
            play(3'b001, 3'b100);
            check("t2_result", round_result, 2'b01);
        end
        check("t2_score_a", score_a, 3);
        check("t2_rounds", round_cnt, 3);
        check("t2_winner", match_winner, 2'b01);
        check("t2_done", match_done, 1);

        // A early, a second A offer ignored, B late.
        pulse_start();
        @(negedge clk); move_a = 3'b010; move_a_valid = 1'b1;
        @(negedge clk); move_a = 3'b100;
        repeat (5) begin
            check("t3_ready_a_low", move_a_ready, 0);
            @(negedge clk);
        end
        move_b = 3'b001; move_b_valid = 1'b1;
        @(negedge clk); move_a_valid = 1'b0; move_b_valid = 1'b0;
        wait_round();
        check("t3_judge_a", judge_a, 3'b010);
        check("t3_result", round_result, 2'b01);

        // Illegal move, then forced verdicts to pin decode priority.
        play(3'b011, 3'b001);
        check("t4_result", round_result, 2'b00);
        check("t4_rounds", round_cnt, 1);
        check("t4_ready_a", move_a_ready, 1);
        check("t4_ready_b", move_b_ready, 1);
        play_forced(3'b001, 3'b100, 4'b0010);
        check("prio_invalid", round_result, 2'b00);
        play_forced(3'b001, 3'b100, 4'b1101);
        check("prio_tie", round_result, 2'b11);
        play_forced(3'b001, 3'b100, 4'b1011);
        check("prio_win_a", round_result, 2'b01);
        check("prio_rounds", round_cnt, 3);
        play(3'b100, 3'b010);
        check("win_over_draw", match_winner, 2'b01);
        check("win_over_draw_cnt", round_cnt, 4);

        // Draw at the round limit, then restart.
        pulse_start();
        repeat (4) play(3'b001, 3'b001);
        check("t5_rounds", round_cnt, 4);
        check("t5_winner", match_winner, 2'b11);
        check("t5_done", match_done, 1);
        pulse_start();
        check("t5_restart_cnt", round_cnt, 0);
        check("t5_restart_done", match_done, 0);
        check("t5_restart_busy", busy, 1);

        // B takes the match; valid wiggling in DONE and start in COLLECT do nothing.
        repeat (3) play(3'b001, 3'b010);
        check("t6_winner", match_winner, 2'b10);
        check("t6_score_b", score_b, 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            move_a_valid = i[0]; move_b_valid = !i[0];
            check("t6_ready_a_done", move_a_ready, 0);
        end
        move_a_valid = 1'b0; move_b_valid = 1'b0;
        check("t6_judge_b_held", judge_b, 3'b010);
        pulse_start();
        pulse_start();
        check("t6_start_ignored", busy, 1);
        play(3'b010, 3'b100);
        check("t6_after_ignore", score_b, 1);

        // Reset during the JUDGE cycle suppresses round_done.
        @(negedge clk);
        move_a = 3'b001; move_b = 3'b100; move_a_valid = 1'b1; move_b_valid = 1'b1;
        @(negedge clk); move_a_valid = 1'b0; move_b_valid = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("mid_judge_no_done", round_done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_judge_score", score_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
